hazard_dest_pipe: RTL and testbench



---
 rtl/hazard_dest_pipe.sv | 144 ++++++++++++++
 tb/tb_hazard_dest_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_dest_pipe.sv
// ---------------------------------------------------------------------------
// hazard_dest_pipe
//
// Carries source/destination register information for in-flight
// instructions through the ID/EX, EX/MEM and MEM/WB stages. It drives the
// forwarding unit and detects load-use hazards. A load-use hazard produces
// a one-cycle stall, and a saturating counter records each stall cycle.
//
// Parameters
//   REG_W   register-index width
//   CNT_W   stall-counter width
//
// Ports
//   clk            pipeline clock; all state updates on the rising edge
//   rst            synchronous, active-high reset
//   id_valid       ID stage holds a real instruction
//   id_rs, id_rt   source registers of the ID instruction
//   id_uses_rt     ID instruction reads rt as an operand
//   id_dest        destination register of the ID instruction
//   id_regwrite    ID instruction writes the register file
//   id_memread     ID instruction is a load
//   flush          taken branch/jump resolved in EX; kill the ID instruction
//   cnt_clr        clear the stall counter
//   IDEX_Rs/Rt     rs/rt held in ID/EX
//   MemDest        dest held in EX/MEM
//   MEM_RegWrite   EX/MEM instruction writes a register
//   WriteBackDest  dest held in MEM/WB
//   RegWriteWB     MEM/WB instruction writes a register
//   stall          load-use stall: hold PC and IF/ID, insert a bubble
//   stall_cnt      saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_dest_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [REG_W-1:0] IDEX_Rs,
  output logic [REG_W-1:0] IDEX_Rt,
  output logic [REG_W-1:0] MemDest,
  output logic             MEM_RegWrite,
  output logic [REG_W-1:0] WriteBackDest,
  output logic             RegWriteWB,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic             rw;
    logic             mr;
  } idex_t;

  // The load flag is only needed in ID/EX. Nothing downstream of EX
  // consumes it, so the later stages hold only valid, dest and rw.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             rw;
  } late_t;

  idex_t idex_q, idex_d;
  late_t exmem_q, exmem_d;
  late_t memwb_q;

  logic hz;
  logic rt_match;
  logic rs_match;

  // Load-use detect. A load to $0 is never a producer.
  always_comb begin
    rs_match = (idex_q.dest == id_rs);
    rt_match = id_uses_rt && (idex_q.dest == id_rt);
    hz       = idex_q.valid && idex_q.mr && (idex_q.dest != '0) &&
               id_valid && (rs_match || rt_match);
    // A flushed ID instruction is discarded, so it cannot cause a stall.
    stall    = hz && !flush;
  end

  // ID/EX next value. A bubble has every field at 0, so all outputs read
  // as 0 while it moves down the pipe.
  always_comb begin
    idex_d = '0;
    if (id_valid && !flush && !stall) begin
      idex_d.valid = 1'b1;
      idex_d.rs    = id_rs;
      idex_d.rt    = id_rt;
      idex_d.dest  = id_dest;
      // A write to $0 is discarded here, so it never shows as active.
      idex_d.rw    = id_regwrite && (id_dest != '0);
      idex_d.mr    = id_memread;
    end
  end

  always_comb begin
    exmem_d       = '0;
    exmem_d.valid = idex_q.valid;
    exmem_d.dest  = idex_q.dest;
    exmem_d.rw    = idex_q.rw;
  end

  // EX/MEM and MEM/WB never stall; they advance every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= exmem_q;
    end
  end

  // Stall counter. Clear wins over increment, and the count saturates
  // instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign IDEX_Rs       = idex_q.rs;
  assign IDEX_Rt       = idex_q.rt;
  assign MemDest       = exmem_q.dest;
  assign MEM_RegWrite  = exmem_q.valid && exmem_q.rw;
  assign WriteBackDest = memwb_q.dest;
  assign RegWriteWB    = memwb_q.valid && memwb_q.rw;

endmodule

// File: tb/tb_hazard_dest_pipe.sv
module tb_hazard_dest_pipe;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt, id_dest;
  logic             id_uses_rt, id_regwrite, id_memread;
  logic             flush, cnt_clr;
  logic [REG_W-1:0] IDEX_Rs, IDEX_Rt, MemDest, WriteBackDest;
  logic             MEM_RegWrite, RegWriteWB, stall;
  logic [CNT_W-1:0] stall_cnt;

  hazard_dest_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush), .cnt_clr(cnt_clr),
    .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .MemDest(MemDest),
    .MEM_RegWrite(MEM_RegWrite), .WriteBackDest(WriteBackDest),
    .RegWriteWB(RegWriteWB), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       ut;
    logic [4:0] dest;
    logic       rw, mr, fl, clr;
    logic       e_stall;
    logic [4:0] e_irs, e_irt, e_md;
    logic       e_mrw;
    logic [4:0] e_wd;
    logic       e_rwb;
    logic [3:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ut,
    input logic [4:0] dest, input logic rw, input logic mr, input logic fl,
    input logic clr, input logic es, input logic [4:0] irs, input logic [4:0] irt,
    input logic [4:0] md, input logic mrw, input logic [4:0] wd, input logic rwb,
    input logic [3:0] cnt);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.ut = ut; r.dest = dest; r.rw = rw;
    r.mr = mr; r.fl = fl; r.clr = clr; r.e_stall = es; r.e_irs = irs;
    r.e_irt = irt; r.e_md = md; r.e_mrw = mrw; r.e_wd = wd; r.e_rwb = rwb;
    r.e_cnt = cnt;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut, input logic [4:0] dest, input logic rw,
                       input logic mr, input logic fl, input logic clr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut; id_dest = dest;
    id_regwrite = rw; id_memread = mr; flush = fl; cnt_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] irs, input logic [4:0] irt,
                          input logic [4:0] md, input logic mrw, input logic [4:0] wd,
                          input logic rwb, input logic [3:0] cnt);
    chk({tag, ".IDEX_Rs"},       32'(IDEX_Rs),       32'(irs));
    chk({tag, ".IDEX_Rt"},       32'(IDEX_Rt),       32'(irt));
    chk({tag, ".MemDest"},       32'(MemDest),       32'(md));
    chk({tag, ".MEM_RegWrite"},  32'(MEM_RegWrite),  32'(mrw));
    chk({tag, ".WriteBackDest"}, 32'(WriteBackDest), 32'(wd));
    chk({tag, ".RegWriteWB"},    32'(RegWriteWB),    32'(rwb));
    chk({tag, ".stall_cnt"},     32'(stall_cnt),     32'(cnt));
  endtask

  vec_t tbl[20];

  initial begin
    int cnt_m;
    logic exp_st;

    // ALU chain, load-use on rt, uses_rt=0, $0 load, flush priority,
    // chained loads, clear on a stall cycle, drain.
    //          v  rs  rt ut dst rw mr fl clr | st | irs irt md mrw wd rwb cnt
    tbl[0]  = mk(1,  1,  2, 1,  3, 1, 0, 0, 0,  0,  1,  2,  0, 0,  0, 0, 0);
    tbl[1]  = mk(1,  3,  4, 1,  6, 1, 0, 0, 0,  0,  3,  4,  3, 1,  0, 0, 0);
    tbl[2]  = mk(0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  0,  6, 1,  3, 1, 0);
    tbl[3]  = mk(1,  2,  0, 0,  5, 1, 1, 0, 0,  0,  2,  0,  0, 0,  6, 1, 0);
    tbl[4]  = mk(1,  7,  5, 1,  8, 1, 0, 0, 0,  1,  0,  0,  5, 1,  0, 0, 1);
    tbl[5]  = mk(1,  7,  5, 1,  8, 1, 0, 0, 0,  0,  7,  5,  0, 0,  5, 1, 1);
    tbl[6]  = mk(1,  1,  0, 0,  9, 1, 1, 0, 0,  0,  1,  0,  8, 1,  0, 0, 1);
    tbl[7]  = mk(1,  3,  9, 0, 10, 1, 0, 0, 0,  0,  3,  9,  9, 1,  8, 1, 1);
    tbl[8]  = mk(1,  4,  0, 0,  0, 1, 1, 0, 0,  0,  4,  0, 10, 1,  9, 1, 1);
    tbl[9]  = mk(1,  0,  0, 1, 11, 1, 0, 0, 0,  0,  0,  0,  0, 0, 10, 1, 1);
    tbl[10] = mk(1,  1,  0, 0, 12, 1, 1, 0, 0,  0,  1,  0, 11, 1,  0, 0, 1);
    tbl[11] = mk(1, 12,  2, 1, 13, 1, 0, 1, 0,  0,  0,  0, 12, 1, 11, 1, 1);
    tbl[12] = mk(1,  1,  0, 0, 14, 1, 1, 0, 0,  0,  1,  0,  0, 0, 12, 1, 1);
    tbl[13] = mk(1, 14,  0, 0, 15, 1, 1, 0, 0,  1,  0,  0, 14, 1,  0, 0, 2);
    tbl[14] = mk(1, 14,  0, 0, 15, 1, 1, 0, 0,  0, 14,  0,  0, 0, 14, 1, 2);
    tbl[15] = mk(1, 15,  1, 1, 16, 1, 0, 0, 1,  1,  0,  0, 15, 1,  0, 0, 0);
    tbl[16] = mk(1, 15,  1, 1, 16, 1, 0, 0, 0,  0, 15,  1,  0, 0, 15, 1, 0);
    tbl[17] = mk(0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  0, 16, 1,  0, 0, 0);
    tbl[18] = mk(0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  0,  0, 0, 16, 1, 0);
    tbl[19] = mk(0,  0,  0, 0,  0, 0, 0, 0, 0,  0,  0,  0,  0, 0,  0, 0, 0);

    // Reset with random inputs for two cycles.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset.stall", 32'(stall), 32'd0);
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].ut, tbl[i].dest, tbl[i].rw,
            tbl[i].mr, tbl[i].fl, tbl[i].clr);
      #1;
      chk($sformatf("row%0d.stall", i), 32'(stall), 32'(tbl[i].e_stall));
      tick();
      chk_outs($sformatf("row%0d", i), tbl[i].e_irs, tbl[i].e_irt, tbl[i].e_md,
               tbl[i].e_mrw, tbl[i].e_wd, tbl[i].e_rwb, tbl[i].e_cnt);
    end

    // Saturation: lw $5,0($5) held in ID stalls on every other cycle.
    cnt_m = 0;
    drive(1, 5, 0, 0, 5, 1, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      exp_st = (i % 2) == 1;
      #1;
      chk($sformatf("sat%0d.stall", i), 32'(stall), 32'(exp_st));
      tick();
      if (exp_st && cnt_m < 15) cnt_m++;
      chk($sformatf("sat%0d.cnt", i), 32'(stall_cnt), 32'(cnt_m));
    end
    chk("sat.final", 32'(stall_cnt), 32'd15);

    // One accept cycle, then clear on the following stall cycle.
    #1;
    chk("pre_clr.stall", 32'(stall), 32'd0);
    tick();
    chk("pre_clr.cnt", 32'(stall_cnt), 32'd15);
    cnt_clr = 1'b1;
    #1;
    chk("clr.stall", 32'(stall), 32'd1);
    tick();
    chk("clr.cnt", 32'(stall_cnt), 32'd0);
    cnt_clr = 1'b0;

    // Three ALU instructions in flight, then reset for one cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2, 1, 5'(20 + i), 1, 0, 0, 0);
      tick();
    end
    chk_outs("inflight", 1, 2, 21, 1, 20, 1, 0);
    rst = 1'b1;
    drive(1, 3, 4, 1, 23, 1, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midrst.stall", 32'(stall), 32'd0);
    chk_outs("midrst", 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish by 100000, expected finish earlier");
    $fatal(1);
  end

endmodule
